// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: frame states, byte width, line levels.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  // Serial line levels
  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } frameState_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic evenParity(input logic [UART_DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO feeding the UART serializer; head byte is visible combinationally on rdData.
// Latency: a write at edge N is visible (empty=0, level) after edge N; pop takes effect at the edge.
// Backpressure: writes while full are dropped and latch the sticky overflowErr flag.
// Ports: sys_clk/sys_rst_l clock and async active-low reset; wrEn/wrData write side;
//        rdEn/rdData pop side; full/empty/level occupancy; overflowErr sticky drop flag.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_l,
  input  logic                        wrEn,
  input  logic [UART_DATA_BITS-1:0]   wrData,
  input  logic                        rdEn,
  output logic [UART_DATA_BITS-1:0]   rdData,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflowErr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [UART_DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wrPtr;
  logic [AW-1:0]             rdPtr;
  logic [LW-1:0]             count;
  logic                      wrAccept;
  logic                      rdAccept;

  assign full   = (count == LW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign level  = count;
  assign rdData = mem[rdPtr];

  // A write into a full FIFO is dropped even if a pop frees a slot in the same cycle.
  assign wrAccept = wrEn & ~full;
  assign rdAccept = rdEn & ~empty;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      count       <= '0;
      overflowErr <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + AW'(1);
      if (rdAccept) rdPtr <= rdPtr + AW'(1);
      if (wrEn && full) overflowErr <= 1'b1;
      case ({wrAccept, rdAccept})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge sys_clk) begin
    if (wrAccept) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/uart_xmit_fifo.sv
// Buffered UART transmitter: queues bytes in a FIFO and sends back-to-back 8N1 (optional even parity) frames.
// Latency: write at edge N -> pop at N+1 -> start bit on uart_XMIT_dataH after edge N+2.
// Backpressure: fullH warns the writer; writes while full are dropped and set overflow_errH (sticky).
// Ports: sys_clk/sys_rst_l clock and async active-low reset; wr_enH/wr_dataH write port;
//        fullH/emptyH/levelH/overflow_errH FIFO status; uart_XMIT_dataH serial line;
//        busyH frame in progress; xmit_doneH one-cycle pulse at frame end.
module uart_xmit_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_l,
  input  logic                        wr_enH,
  input  logic [UART_DATA_BITS-1:0]   wr_dataH,
  output logic                        fullH,
  output logic                        emptyH,
  output logic [$clog2(FIFO_DEPTH):0] levelH,
  output logic                        overflow_errH,
  output logic                        uart_XMIT_dataH,
  output logic                        busyH,
  output logic                        xmit_doneH
);

  localparam int              CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LAST_IDX = 3'(UART_DATA_BITS - 1);

  frameState_t               state;
  logic [CW-1:0]             bitCnt;
  logic [2:0]                bitIdx;
  logic [UART_DATA_BITS-1:0] shiftReg;
  logic                      parityBit;
  logic                      bitLast;
  logic                      pop;
  logic [UART_DATA_BITS-1:0] headByte;

  uart_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk     (sys_clk),
    .sys_rst_l   (sys_rst_l),
    .wrEn        (wr_enH),
    .wrData      (wr_dataH),
    .rdEn        (pop),
    .rdData      (headByte),
    .full        (fullH),
    .empty       (emptyH),
    .level       (levelH),
    .overflowErr (overflow_errH)
  );

  assign bitLast = (bitCnt == LAST);

  // Pop from IDLE, or on the last STOP cycle so the next start bit follows with no idle gap.
  assign pop = ~emptyH & ((state == IDLE) | ((state == STOP) & bitLast));

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state           <= IDLE;
      bitCnt          <= '0;
      bitIdx          <= '0;
      shiftReg        <= '0;
      parityBit       <= 1'b0;
      uart_XMIT_dataH <= LINE_IDLE;
      busyH           <= 1'b0;
      xmit_doneH      <= 1'b0;
    end else begin
      // Outputs are registered decodes of the state held during the previous cycle,
      // so the line trails the FSM by exactly one cycle.
      busyH      <= (state != IDLE);
      xmit_doneH <= (state == STOP) && bitLast;

      // Every bit state leaves on bitLast, so the counter is zero on entry to each state.
      bitCnt <= ((state == IDLE) || bitLast) ? '0 : bitCnt + CW'(1);

      case (state)
        IDLE: begin
          uart_XMIT_dataH <= LINE_IDLE;
          if (pop) begin
            shiftReg  <= headByte;
            parityBit <= evenParity(headByte);
            state     <= START;
          end
        end
        START: begin
          uart_XMIT_dataH <= LINE_START;
          if (bitLast) begin
            bitIdx <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          uart_XMIT_dataH <= shiftReg[bitIdx];
          if (bitLast) begin
            bitIdx <= bitIdx + 3'd1;
            if (bitIdx == LAST_IDX) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          uart_XMIT_dataH <= parityBit;
          if (bitLast) state <= STOP;
        end
        STOP: begin
          uart_XMIT_dataH <= LINE_STOP;
          if (bitLast) begin
            if (pop) begin
              shiftReg  <= headByte;
              parityBit <= evenParity(headByte);
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          uart_XMIT_dataH <= LINE_IDLE;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule
